// File: rtl/alu_pkg.sv
// Shared ALU stage types: operand widths, opcode encoding and the tagged result record.
// Pure declarations, no logic.
package alu_pkg;

    localparam int RESULT_W = 4;
    localparam int OPCODE_W = 2;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_AND = 2'd3
    } alu_op_e;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [RESULT_W-1:0] result;
        logic                zero;
        logic                msb;
    } alu_result_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Status flag generator: zero and sign/msb flags of an ALU result.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module alu_flag_gen #(
    parameter int W = 4
) (
    input  logic [W-1:0] result,
    output logic         zero,
    output logic         msb
);

    assign zero = (result == '0);
    assign msb  = result[W-1];

endmodule

// File: rtl/alu_result_buffer.sv
// Result FIFO between the ALU units and the readout stage; tags entries with zero/msb flags.
// Latency: push into an empty buffer is visible at the head one cycle later.
// Backpressure: in_ready comes only from registered occupancy, so a full buffer stalls even while popping.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [RESULT_W-1:0]       in_result,
    input  logic [OPCODE_W-1:0]       in_opcode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [RESULT_W-1:0]       out_result,
    output logic [OPCODE_W-1:0]       out_opcode,
    output logic                      out_zero,
    output logic                      out_msb,
    output logic [$clog2(DEPTH):0]    count,
    output logic [CNT_W-1:0]          accepted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    alu_result_t      mem [DEPTH];
    alu_result_t      head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;
    logic             in_zero;
    logic             in_msb;

    alu_flag_gen #(.W(RESULT_W)) u_flag_gen (
        .result (in_result),
        .zero   (in_zero),
        .msb    (in_msb)
    );

    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Storage needs no reset: entries past count are never presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{opcode: in_opcode, result: in_result,
                             zero: in_zero, msb: in_msb};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            accepted <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (accepted != '1) begin
                    accepted <= accepted + CNT_W'(1);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        head = '0;
        if (out_valid) begin
            head = mem[rd_ptr];
        end
    end

    assign out_result = head.result;
    assign out_opcode = head.opcode;
    assign out_zero   = head.zero;
    assign out_msb    = head.msb;

endmodule
